keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 3×4 matrix keypad and produces the debounced 12-bit one-hot `key_data` bus that the menu and game state blocks consume, for example where key 1 (bit 0) leaves the main menu. It drives the columns one at a time, samples the rows through a synchroniser, and assembles a full-frame key image. Only a single key held stable over several frames is reported. It sits between the board keypad pins and every block that reads `key_data`.

## Interface
- `SCAN_DIV`, default 25000: clk cycles per column slot (1 ms per slot at 25 MHz).
- `DEBOUNCE`, default 4: number of consecutive identical frames required before `key_data` changes (≥2).
- `clk  in  1`: system clock.
- `rst  in  1`: reset. One clock; reset is synchronous and active-high.
- `key_row  in  4`: keypad row inputs, asynchronous. High = pressed key in the currently driven column.
- `key_col  out  3`: one-hot active-high column drive.
- `key_data  out  12`: debounced one-hot key. Bit `row*3+col` (bit 0 = key 1, bit 11 = key 12). All-zero = no key.
- `key_valid  out  1`: one-clk pulse when `key_data` takes a new non-zero value.

## Operation
- Rows pass through a 2-flop synchroniser before any use.
- Slot counter runs 0..SCAN_DIV-1. Column index `col` cycles 0→1→2→0, advancing when the slot counter wraps. `key_col` = `1 << col`.
- Sampling: on the last cycle of a slot (count = SCAN_DIV-1), the synchronised rows are written into frame bits `{row*3+col}` for rows 0..3.
- Frame end: after the col-2 sample, `candidate` = frame if popcount(frame) == 1, else 12'h000. Ghost and multi-key frames therefore count as "no key".
- Debounce, evaluated once per frame end:
  - If `candidate` == `last_cand`, `stable_cnt` increments, saturating at DEBOUNCE-1.
  - Otherwise `last_cand` ← `candidate` and `stable_cnt` ← 0.
  - When `stable_cnt` reaches DEBOUNCE-1 (i.e. DEBOUNCE identical frames) and `last_cand` ≠ `key_data`, then `key_data` ← `last_cand`.
  - In that same update, `key_valid` is asserted for one cycle iff the new value is non-zero.
- Changing directly from one key to a different key (no zero frames in between) updates `key_data` to the new key and pulses `key_valid`.
- Holding a key does not re-pulse `key_valid`; no auto-repeat.
- `rst` mid-frame aborts the frame. The partial frame, `last_cand` and `stable_cnt` are all discarded.

## Timing
- Reset values:
  - `key_col` = 3'b001, `key_data` = 12'h000, `key_valid` = 0.
  - Slot counter = 0, `col` = 0, frame = 0, `last_cand` = 0, `stable_cnt` = 0.
  - Synchroniser flops = 0.
- Frame length: 3·SCAN_DIV cycles.
- Sample point: SCAN_DIV-1 cycles after the column switch. This gives the 2-flop synchroniser enough settle time when SCAN_DIV ≥ 4.
- `key_data` and `key_valid` update on the clk edge after the col-2 sample cycle, i.e. registered one cycle after frame end.
- Press latency from the first frame fully containing a stable press: DEBOUNCE frames + 1 clk.
- Release latency: the same, counted from the first all-zero frame.
- A key pressed or released mid-frame makes that frame indeterminate. Debounce absorbs it.

## Structure
- Shared package holds:
  - `KP_ROWS` = 4, `KP_COLS` = 3, `KP_KEYS` = 12.
  - `KP_COL_RESET` = 3'b001.
  - Named key constants, e.g. `KEY_1` = 12'h001 … `KEY_12` = 12'h800, for use by the menu and game state blocks.
- One sub-module, `row_sync`: 4-bit two-flop synchroniser with synchronous reset.
- Column drive, frame assembly and debounce stay in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3 unless stated.
- Hold row0 in col0 (key 1) from reset → `key_col` cycles 001/010/100 every 4 clk. `key_data` = 12'h001 after 3 frames + 1 clk. Exactly one `key_valid` pulse.
- Key 12 (row3 asserted only while col2 is driven) → `key_data` = 12'h800, one pulse. Release → 12'h000 three frames later, with no pulse.
- Key 5 alternating pressed/released every frame for 10 frames → `key_data` stays 12'h000 and `key_valid` never asserts.
- Keys 1 and 2 held together → `key_data` stays 12'h000. Then release key 2 → 12'h001 three frames later, with a pulse.
- Key 1 held stable, then switched directly to key 3 → `key_data` 12'h001 → 12'h004 with a second `key_valid` pulse and no intervening zero.
- Assert `rst` mid-slot with key 1 stable for 2 frames → next cycle `key_col` = 001 and outputs are 0. Counting restarts: 3 more full frames are needed before 12'h001 appears.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared keypad geometry, reset column drive and one-hot key codes used by
// the scanner and by every block that consumes key_data.
package keypad_scanner_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 3;
    localparam int KP_KEYS = 12;

    localparam logic [KP_COLS-1:0] KP_COL_RESET = 3'b001;

    localparam logic [KP_KEYS-1:0] KEY_1  = 12'h001;
    localparam logic [KP_KEYS-1:0] KEY_2  = 12'h002;
    localparam logic [KP_KEYS-1:0] KEY_3  = 12'h004;
    localparam logic [KP_KEYS-1:0] KEY_4  = 12'h008;
    localparam logic [KP_KEYS-1:0] KEY_5  = 12'h010;
    localparam logic [KP_KEYS-1:0] KEY_6  = 12'h020;
    localparam logic [KP_KEYS-1:0] KEY_7  = 12'h040;
    localparam logic [KP_KEYS-1:0] KEY_8  = 12'h080;
    localparam logic [KP_KEYS-1:0] KEY_9  = 12'h100;
    localparam logic [KP_KEYS-1:0] KEY_10 = 12'h200;
    localparam logic [KP_KEYS-1:0] KEY_11 = 12'h400;
    localparam logic [KP_KEYS-1:0] KEY_12 = 12'h800;

    // True when exactly one key is set in a frame image.
    function automatic logic is_one_hot(input logic [KP_KEYS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < KP_KEYS; i++) begin
            n += int'(v[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchroniser bringing the asynchronous keypad rows into the clk domain.
module row_sync
    import keypad_scanner_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [KP_ROWS-1:0] row_i,
    output logic [KP_ROWS-1:0] row_o
);

    logic [KP_ROWS-1:0] meta_q;
    logic [KP_ROWS-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= row_i;
            sync_q <= meta_q;
        end
    end

    assign row_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: column drive, frame assembly, single-key filter and
// frame-level debounce producing a one-hot key_data bus with a new-key pulse.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 25000,
    parameter int DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KP_ROWS-1:0] key_row,
    output logic [KP_COLS-1:0] key_col,
    output logic [KP_KEYS-1:0] key_data,
    output logic               key_valid
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STB_W = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE - 1);

    logic [KP_ROWS-1:0] row_s;

    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [1:0]         col_q,       col_d;
    logic [KP_KEYS-1:0] frame_q,     frame_d;
    logic [KP_KEYS-1:0] last_cand_q, last_cand_d;
    logic [STB_W-1:0]   stable_q,    stable_d;
    logic               done_q,      done_d;
    logic [KP_KEYS-1:0] key_data_q,  key_data_d;
    logic               key_valid_q, key_valid_d;

    logic               slot_end;
    logic               frame_end;
    logic               update;
    logic [KP_KEYS-1:0] frame_full;
    logic [KP_KEYS-1:0] candidate;

    row_sync u_row_sync (
        .clk_i (clk),
        .rst_i (rst),
        .row_i (key_row),
        .row_o (row_s)
    );

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (col_q == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            col_q       <= '0;
            frame_q     <= '0;
            last_cand_q <= '0;
            stable_q    <= '0;
            done_q      <= 1'b0;
            key_data_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            frame_q     <= frame_d;
            last_cand_q <= last_cand_d;
            stable_q    <= stable_d;
            done_q      <= done_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Slot timing and frame assembly; the last cycle of each slot latches the rows.
    always_comb begin
        cnt_d      = slot_end ? '0 : cnt_q + CNT_W'(1);
        col_d      = col_q;
        frame_full = frame_q;
        if (slot_end) begin
            col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
            for (int r = 0; r < KP_ROWS; r++) begin
                for (int c = 0; c < KP_COLS; c++) begin
                    if (col_q == 2'(c)) begin
                        frame_full[r*KP_COLS + c] = row_s[r];
                    end
                end
            end
        end
        frame_d   = frame_end ? '0 : frame_full;
        candidate = is_one_hot(frame_full) ? frame_full : '0;
    end

    // Debounce bookkeeping at frame end; the output decision follows one cycle later.
    always_comb begin
        last_cand_d = last_cand_q;
        stable_d    = stable_q;
        done_d      = frame_end;
        if (frame_end) begin
            if (candidate == last_cand_q) begin
                stable_d = (stable_q == STB_MAX) ? STB_MAX : stable_q + STB_W'(1);
            end else begin
                last_cand_d = candidate;
                stable_d    = '0;
            end
        end
    end

    always_comb begin
        update      = done_q && (stable_q == STB_MAX) && (last_cand_q != key_data_q);
        key_data_d  = update ? last_cand_q : key_data_q;
        key_valid_d = update && (last_cand_q != '0);
    end

    assign key_col   = KP_COL_RESET << col_q;
    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, frame-level reference model
// of the single-key debounce, directed scenarios followed by random traffic.
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 3 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] key_data;
    logic        key_valid;

    logic [11:0] pressed;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          cyc;
    logic [11:0] exp_key;
    logic        exp_valid;
    logic        pend;
    logic [11:0] pend_key;
    logic [11:0] hist[$];

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_data  (key_data),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key connects its column drive to its row.
    always_comb begin
        key_row = '0;
        for (int r = 0; r < 4; r++) begin
            key_row[r] = |(pressed[r*3 +: 3] & key_col);
        end
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] exp_col;
        exp_col = 3'b001 << ((cyc / SCAN_DIV) % 3);
        check("key_col",   {9'd0, key_col},   {9'd0, exp_col});
        check("key_data",  key_data,          exp_key);
        check("key_valid", {11'd0, key_valid}, {11'd0, exp_valid});
    endtask

    // Frame-level rule: a frame counts as its key only if exactly one key is down;
    // key_data follows when the last DEBOUNCE frames all agree on a new value.
    task automatic model_frame_end();
        logic [11:0] cand;
        logic        agree;
        cand = ($countones(pressed) == 1) ? pressed : 12'h000;
        hist.push_back(cand);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        agree = (hist.size() == DEBOUNCE);
        foreach (hist[i]) if (hist[i] != cand) agree = 1'b0;
        if (agree && cand != exp_key) begin
            pend     = 1'b1;
            pend_key = cand;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        exp_valid = 1'b0;
        if (pend) begin
            exp_key   = pend_key;
            exp_valid = (pend_key != 12'h000);
            pend      = 1'b0;
        end
        if (cyc % FRAME == 0) model_frame_end();
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cyc       = 0;
        pend      = 1'b0;
        exp_key   = 12'h000;
        exp_valid = 1'b0;
        hist.delete();
        check_outputs();
    endtask

    task automatic run_frames(input logic [11:0] p, input int n);
        pressed = p;
        repeat (n * FRAME) tick();
    endtask

    initial begin
        logic [11:0] cur;
        int          sel;
        rst      = 1'b1;
        pressed  = 12'h000;
        cyc      = 0;
        pend     = 1'b0;
        pend_key = 12'h000;
        repeat (3) @(posedge clk);
        do_reset();

        // Key 1 held from reset, then key 12 pressed and released
        run_frames(KEY_1, 4);
        run_frames(KEY_12, 4);
        run_frames(12'h000, 4);

        // Key 5 bouncing every frame never settles
        for (int i = 0; i < 10; i++) run_frames((i % 2 == 0) ? KEY_5 : 12'h000, 1);

        // Two keys together read as nothing; releasing one reports the other
        run_frames(KEY_1 | KEY_2, 4);
        run_frames(KEY_1, 4);

        // Direct key-to-key change
        run_frames(KEY_3, 4);
        run_frames(12'h000, 4);

        // Reset mid-frame after two stable frames of key 1
        run_frames(KEY_1, 2);
        repeat (5) tick();
        do_reset();
        run_frames(KEY_1, 4);

        // Random traffic biased toward holding so presses get through debounce
        cur = KEY_1;
        for (int f = 0; f < 80; f++) begin
            sel = $urandom_range(0, 19);
            if (sel < 11) begin
                cur = cur;
            end else if (sel < 15) begin
                cur = 12'h001 << $urandom_range(0, 11);
            end else if (sel < 17) begin
                cur = 12'h000;
            end else if (sel < 19) begin
                cur = (12'h001 << $urandom_range(0, 11)) | (12'h001 << $urandom_range(0, 11));
            end else begin
                pressed = cur;
                repeat ($urandom_range(1, FRAME - 1)) tick();
                do_reset();
            end
            run_frames(cur, 1);
        end
        run_frames(cur, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
